// File: rtl/counter_param.sv
// counter_param: parametrised multi-mode up/down counter.
//
// Counts up by 1, down by 1, up by STEP, or loads a value, with either
// saturating or modulo-(TOP+1) arithmetic. Reports overflow/underflow with a
// one-cycle rco pulse, acknowledges loads with a one-cycle load_ack pulse,
// and keeps a saturating 8-bit count of rco events since reset or last load.
//
// Optional feature macro: COUNTER_PRESCALE_EN
//   When defined, up/down operations take effect only on every PRESC-th
//   enabled cycle; loads remain immediate and clear the prescaler.
//
// Parameters:
//   WIDTH  counter width (>= 2)
//   TOP    terminal count, legal range of Q is 0..TOP (TOP >= 1)
//   STEP   increment for modo=2'b10 (0 makes that mode a hold)
//   PRESC  prescale ratio (>= 1), used only with COUNTER_PRESCALE_EN
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   enb       enable; 0 holds Q and wraps, clears the pulses
//   modo      00 up 1, 01 down 1, 10 up STEP, 11 load
//   sat       1 saturate at bounds, 0 wrap
//   data      load value (clamped to TOP)
//   Q         registered count
//   rco       registered overflow/underflow pulse
//   load_ack  registered pulse following a load
//   wraps     saturating count of rco events
module counter_param #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TOP   = {WIDTH{1'b1}},
  parameter int unsigned      STEP  = 3,
  parameter int unsigned      PRESC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic [1:0]       modo,
  input  logic             sat,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] Q,
  output logic             rco,
  output logic             load_ack,
  output logic [7:0]       wraps
);

  // One extra bit so that Q+STEP cannot truncate before the TOP comparison.
  localparam logic [WIDTH:0]   ZERO_X = {(WIDTH+1){1'b0}};
  localparam logic [WIDTH:0]   ONE_X  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   TOP_X  = {1'b0, TOP};
  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   WRAP_X = TOP_X + ONE_X;
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_r, q_nxt_s;
  logic             rco_r, rco_nxt_s;
  logic             ack_r, ack_nxt_s;
  logic [7:0]       wraps_r, wraps_nxt_s;
  logic [WIDTH:0]   inc_x_s, sum_x_s;
  logic             tick_s;

`ifdef COUNTER_PRESCALE_EN
  localparam int unsigned PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESC - 1);
  localparam logic [PW-1:0] PZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PONE  = PW'(1);

  logic [PW-1:0] pre_r, pre_nxt_s;

  // Prescaler next state: advances on enabled count cycles, cleared by load.
  always_comb begin
    tick_s    = (pre_r == PLAST);
    pre_nxt_s = pre_r;
    if (!enb) begin
      pre_nxt_s = pre_r;
    end else if (modo == 2'b11) begin
      pre_nxt_s = PZERO;
    end else if (tick_s) begin
      pre_nxt_s = PZERO;
    end else begin
      pre_nxt_s = pre_r + PONE;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_r <= PZERO;
    end else begin
      pre_r <= pre_nxt_s;
    end
  end
`else
  assign tick_s = 1'b1;
`endif

  // Next-state logic for count, pulses and wrap counter.
  always_comb begin
    q_nxt_s     = q_r;
    rco_nxt_s   = 1'b0;
    ack_nxt_s   = 1'b0;
    wraps_nxt_s = wraps_r;
    inc_x_s     = modo[1] ? STEP_X : ONE_X;
    sum_x_s     = {1'b0, q_r} + inc_x_s;

    if (!enb) begin
      q_nxt_s = q_r;
    end else if (modo == 2'b11) begin
      q_nxt_s     = (data <= TOP) ? data : TOP;
      ack_nxt_s   = 1'b1;
      wraps_nxt_s = 8'd0;
    end else if (!tick_s) begin
      q_nxt_s = q_r;
    end else begin
      case (modo)
        2'b00, 2'b10: begin
          if (inc_x_s == ZERO_X) begin
            q_nxt_s = q_r;
          end else if (sum_x_s <= TOP_X) begin
            q_nxt_s = sum_x_s[WIDTH-1:0];
          end else if (sat) begin
            // Also covers Q==TOP already: holds at TOP and reports a clip.
            q_nxt_s   = TOP;
            rco_nxt_s = 1'b1;
          end else begin
            // Result is below TOP+1, so the low WIDTH bits are exact.
            q_nxt_s   = sum_x_s[WIDTH-1:0] - WRAP_X[WIDTH-1:0];
            rco_nxt_s = 1'b1;
          end
        end
        2'b01: begin
          if (q_r != ZERO_W) begin
            q_nxt_s = q_r - ONE_W;
          end else if (sat) begin
            q_nxt_s   = ZERO_W;
            rco_nxt_s = 1'b1;
          end else begin
            q_nxt_s   = TOP;
            rco_nxt_s = 1'b1;
          end
        end
        default: begin
          q_nxt_s = q_r;
        end
      endcase

      if (rco_nxt_s && (wraps_r != 8'hFF)) begin
        wraps_nxt_s = wraps_r + 8'd1;
      end else begin
        wraps_nxt_s = wraps_r;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r     <= ZERO_W;
      rco_r   <= 1'b0;
      ack_r   <= 1'b0;
      wraps_r <= 8'd0;
    end else begin
      q_r     <= q_nxt_s;
      rco_r   <= rco_nxt_s;
      ack_r   <= ack_nxt_s;
      wraps_r <= wraps_nxt_s;
    end
  end

  assign Q        = q_r;
  assign rco      = rco_r;
  assign load_ack = ack_r;
  assign wraps    = wraps_r;

endmodule

// File: tb/tb_counter_param.sv
// Testbench for counter_param (default build, prescaler disabled).
// Instance a: WIDTH=4, TOP=15, STEP=3.  Instance b: WIDTH=4, TOP=9.
module tb_counter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       enb, sat;
  logic [1:0] modo;
  logic [3:0] data;
  logic [3:0] q;
  logic       rco, ack;
  logic [7:0] wraps;

  logic       enb_b, sat_b;
  logic [1:0] modo_b;
  logic [3:0] data_b;
  logic [3:0] q_b;
  logic       rco_b, ack_b;
  logic [7:0] wraps_b;

  counter_param #(.WIDTH(4), .TOP(4'd15), .STEP(3)) dut_a (
    .clk(clk), .rst(rst), .enb(enb), .modo(modo), .sat(sat), .data(data),
    .Q(q), .rco(rco), .load_ack(ack), .wraps(wraps)
  );

  counter_param #(.WIDTH(4), .TOP(4'd9), .STEP(3)) dut_b (
    .clk(clk), .rst(rst), .enb(enb_b), .modo(modo_b), .sat(sat_b), .data(data_b),
    .Q(q_b), .rco(rco_b), .load_ack(ack_b), .wraps(wraps_b)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       enb;
    logic [1:0] modo;
    logic       sat;
    logic [3:0] data;
    logic [3:0] q;
    logic       rco;
    logic       ack;
    logic [7:0] wraps;
  } vec_t;

  typedef struct {
    int         idx;
    logic [3:0] q;
    logic       rco;
    logic       ack;
    logic [7:0] wraps;
  } exp_t;

  localparam int NV = 23;
  vec_t vecs[NV];
  exp_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic e, input logic [1:0] m, input logic s, input logic [3:0] d);
    @(negedge clk);
    enb = e; modo = m; sat = s; data = d;
  endtask

  task automatic step_a(input logic e, input logic [1:0] m, input logic s, input logic [3:0] d);
    drive_a(e, m, s, d);
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic e, input logic [1:0] m, input logic s, input logic [3:0] d);
    @(negedge clk);
    enb_b = e; modo_b = m; sat_b = s; data_b = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   pulses;

    // enb modo sat data | q rco ack wraps
    vecs[0]  = '{1'b1, 2'b11, 1'b0, 4'hA, 4'd10, 1'b0, 1'b1, 8'd0};
    vecs[1]  = '{1'b0, 2'b00, 1'b0, 4'h0, 4'd10, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 4'h0, 4'd10, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 2'b00, 1'b0, 4'h0, 4'd10, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 2'b11, 1'b0, 4'hE, 4'd14, 1'b0, 1'b1, 8'd0};
    vecs[5]  = '{1'b1, 2'b00, 1'b0, 4'h0, 4'd15, 1'b0, 1'b0, 8'd0};
    vecs[6]  = '{1'b1, 2'b00, 1'b0, 4'h0, 4'd0,  1'b1, 1'b0, 8'd1};
    vecs[7]  = '{1'b1, 2'b11, 1'b0, 4'hE, 4'd14, 1'b0, 1'b1, 8'd0};
    vecs[8]  = '{1'b1, 2'b00, 1'b1, 4'h0, 4'd15, 1'b0, 1'b0, 8'd0};
    vecs[9]  = '{1'b1, 2'b00, 1'b1, 4'h0, 4'd15, 1'b1, 1'b0, 8'd1};
    vecs[10] = '{1'b1, 2'b11, 1'b0, 4'hE, 4'd14, 1'b0, 1'b1, 8'd0};
    vecs[11] = '{1'b1, 2'b10, 1'b0, 4'h0, 4'd1,  1'b1, 1'b0, 8'd1};
    vecs[12] = '{1'b1, 2'b11, 1'b0, 4'hE, 4'd14, 1'b0, 1'b1, 8'd0};
    vecs[13] = '{1'b1, 2'b10, 1'b1, 4'h0, 4'd15, 1'b1, 1'b0, 8'd1};
    vecs[14] = '{1'b1, 2'b11, 1'b0, 4'h1, 4'd1,  1'b0, 1'b1, 8'd0};
    vecs[15] = '{1'b1, 2'b01, 1'b0, 4'h0, 4'd0,  1'b0, 1'b0, 8'd0};
    vecs[16] = '{1'b1, 2'b01, 1'b0, 4'h0, 4'd15, 1'b1, 1'b0, 8'd1};
    vecs[17] = '{1'b1, 2'b11, 1'b0, 4'h1, 4'd1,  1'b0, 1'b1, 8'd0};
    vecs[18] = '{1'b1, 2'b01, 1'b1, 4'h0, 4'd0,  1'b0, 1'b0, 8'd0};
    vecs[19] = '{1'b1, 2'b01, 1'b1, 4'h0, 4'd0,  1'b1, 1'b0, 8'd1};
    vecs[20] = '{1'b1, 2'b01, 1'b1, 4'h0, 4'd0,  1'b1, 1'b0, 8'd2};
    vecs[21] = '{1'b0, 2'b01, 1'b1, 4'h0, 4'd0,  1'b0, 1'b0, 8'd2};
    vecs[22] = '{1'b1, 2'b00, 1'b0, 4'h0, 4'd1,  1'b0, 1'b0, 8'd2};

    rst = 1'b1;
    enb = 1'b0; modo = 2'b00; sat = 1'b0; data = 4'h0;
    enb_b = 1'b0; modo_b = 2'b00; sat_b = 1'b0; data_b = 4'h0;

    // Reset state.
    @(posedge clk);
    #1;
    chk("reset_q", q, 0);
    chk("reset_rco", rco, 0);
    chk("reset_ack", ack, 0);
    chk("reset_wraps", wraps, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors through the scoreboard.
    for (int i = 0; i < NV; i++) begin
      drive_a(vecs[i].enb, vecs[i].modo, vecs[i].sat, vecs[i].data);
      e.idx = i; e.q = vecs[i].q; e.rco = vecs[i].rco; e.ack = vecs[i].ack; e.wraps = vecs[i].wraps;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 0, 1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("vec%0d_q", e.idx), q, e.q);
        chk($sformatf("vec%0d_rco", e.idx), rco, e.rco);
        chk($sformatf("vec%0d_ack", e.idx), ack, e.ack);
        chk($sformatf("vec%0d_wraps", e.idx), wraps, e.wraps);
      end
    end

    // Build Q=7, wraps=3, then asynchronous reset between edges.
    step_a(1'b1, 2'b11, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) step_a(1'b1, 2'b01, 1'b1, 4'h0);
    for (int i = 0; i < 7; i++) step_a(1'b1, 2'b00, 1'b0, 4'h0);
    chk("pre_rst_q", q, 7);
    chk("pre_rst_wraps", wraps, 3);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_q", q, 0);
    chk("async_rst_wraps", wraps, 0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_q", q, 1);

    // wraps saturates at 255.
    step_a(1'b1, 2'b11, 1'b0, 4'h0);
    for (int i = 0; i < 260; i++) step_a(1'b1, 2'b01, 1'b1, 4'h0);
    chk("wraps_sat", wraps, 255);
    chk("wraps_sat_q", q, 0);
    chk("wraps_sat_rco", rco, 1);
    step_a(1'b1, 2'b11, 1'b0, 4'h3);
    chk("wraps_clear_on_load", wraps, 0);
    step_a(1'b1, 2'b11, 1'b0, 4'h3);
    chk("ack_repeat_load", ack, 1);
    step_a(1'b1, 2'b00, 1'b0, 4'h0);
    chk("ack_one_cycle", ack, 0);
    chk("after_load_q", q, 4);

    // TOP=9 instance: ten up-counts from 0 wrap exactly once.
    step_b(1'b1, 2'b11, 1'b0, 4'd0);
    chk("b_load0_q", q_b, 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step_b(1'b1, 2'b00, 1'b0, 4'd0);
      if (rco_b) pulses++;
      if (i == 8) chk("b_at_top_q", q_b, 9);
    end
    chk("b_wrap_q", q_b, 0);
    chk("b_rco_pulses", pulses, 1);
    chk("b_wraps", wraps_b, 1);
    step_b(1'b1, 2'b11, 1'b0, 4'd12);
    chk("b_clamp_q", q_b, 9);
    chk("b_clamp_ack", ack_b, 1);
    chk("b_clamp_wraps", wraps_b, 0);
    step_b(1'b1, 2'b10, 1'b0, 4'd0);
    chk("b_step_wrap_q", q_b, 2);
    chk("b_step_wrap_rco", rco_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
